// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit slice.
package lsu_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned IMM_W      = 12;
  localparam int unsigned TAG_W      = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  function automatic logic [31:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(32-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response channel (core <-> LSU) and memory port (LSU <-> data memory).
interface lsu_req_if #(
  parameter int unsigned DATA_W = lsu_pkg::DATA_W_DEF
) ();
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_is_store;
  logic [31:0]                req_base;
  logic [lsu_pkg::IMM_W-1:0]  req_imm;
  logic [DATA_W-1:0]          req_wdata;
  logic [lsu_pkg::TAG_W-1:0]  req_rd;
  logic                       resp_valid;
  logic                       resp_ready;
  logic [DATA_W-1:0]          resp_data;
  logic [lsu_pkg::TAG_W-1:0]  resp_rd;
  logic                       resp_err;

  modport master (
    output req_valid, req_is_store, req_base, req_imm, req_wdata, req_rd, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_err
  );
  modport slave (
    input  req_valid, req_is_store, req_base, req_imm, req_wdata, req_rd, resp_ready,
    output req_ready, resp_valid, resp_data, resp_rd, resp_err
  );
endinterface

interface lsu_mem_if #(
  parameter int unsigned DATA_W = lsu_pkg::DATA_W_DEF,
  parameter int unsigned ADDR_W = lsu_pkg::ADDR_W_DEF
) ();
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;

  modport master (
    output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
    input  mem_rd_data
  );
  modport slave (
    input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
    output mem_rd_data
  );
endinterface

// File: rtl/lsu_addr_gen.sv
// Effective address: base + sext(imm) -> word index plus alignment/range flags.
module lsu_addr_gen
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [31:0]       base_i,
  input  logic [IMM_W-1:0]  imm_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic              misaligned_o,
  output logic              out_of_range_o
);
  logic [31:0] eff;

  always_comb begin
    eff            = base_i + sext_imm(imm_i);
    idx_o          = eff[ADDR_W+1:2];
    misaligned_o   = |eff[1:0];
    out_of_range_o = |eff[31:ADDR_W+2];
  end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding LW/SW requester for the data memory with a valid/ready response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  lsu_req_if.slave   req,
  lsu_mem_if.master  mem
);
  lsu_state_e        state_q, state_d;
  logic              store_q;
  logic [TAG_W-1:0]  rd_q;
  logic              err_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic [ADDR_W-1:0] idx;
  logic              misaligned, out_of_range, bad_addr;
  logic              ready, accept;

  lsu_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .base_i         (req.req_base),
    .imm_i          (req.req_imm),
    .idx_o          (idx),
    .misaligned_o   (misaligned),
    .out_of_range_o (out_of_range)
  );

  assign bad_addr = misaligned | out_of_range;
  assign ready    = (state_q == IDLE) & rst;
  assign accept   = req.req_valid & ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = bad_addr ? RESP : ISSUE;
      ISSUE: state_d = store_q ? RESP : WAIT;
      WAIT:  state_d = RESP;
      RESP:  if (req.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req.req_ready  = ready;
    req.resp_valid = (state_q == RESP);
    req.resp_data  = resp_data_q;
    req.resp_rd    = rd_q;
    req.resp_err   = err_q;
    mem.mem_wr_en  = (state_q == ISSUE) & store_q;
    mem.mem_rd_en  = (state_q == ISSUE) & ~store_q;
    mem.mem_wr_addr = wr_addr_q;
    mem.mem_wr_data = wr_data_q;
    mem.mem_rd_addr = rd_addr_q;
  end

  // Memory address/data registers only load on a good request, so they hold
  // their last driven value across error requests and idle periods.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      store_q     <= 1'b0;
      rd_q        <= '0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_data_q   <= '0;
    end else if (accept) begin
      store_q     <= req.req_is_store;
      rd_q        <= req.req_rd;
      err_q       <= bad_addr;
      resp_data_q <= '0;
      if (!bad_addr) begin
        if (req.req_is_store) begin
          wr_addr_q <= idx;
          wr_data_q <= req.req_wdata;
        end else begin
          rd_addr_q <= idx;
        end
      end
    end else if (state_q == WAIT) begin
      resp_data_q <= mem.mem_rd_data;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed self-checking bench for load_store_unit.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_req_if #(.DATA_W(32)) rif ();
  lsu_mem_if #(.DATA_W(32), .ADDR_W(5)) mif ();

  load_store_unit #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .req (rif),
    .mem (mif)
  );

  // Behavioural 32-word memory with one-cycle read latency.
  logic [31:0] tb_mem [32] = '{default: 32'h0};
  initial mif.mem_rd_data = 32'h0;
  always @(posedge clk) begin
    if (mif.mem_wr_en) tb_mem[mif.mem_wr_addr] <= mif.mem_wr_data;
    if (mif.mem_rd_en) mif.mem_rd_data <= tb_mem[mif.mem_rd_addr];
  end

  logic [31:0] ref_mem [32] = '{default: 32'h0};
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic scramble_req();
    rif.req_is_store = 1'($urandom);
    rif.req_base     = $urandom;
    rif.req_imm      = 12'($urandom);
    rif.req_wdata    = $urandom;
    rif.req_rd       = 5'($urandom);
  endtask

  task automatic run_req(input logic st, input logic [31:0] base, input logic [11:0] imm,
                         input logic [31:0] wdata, input logic [4:0] rd, input int unsigned hold);
    logic [31:0] eff, exp_data;
    logic        err;
    int unsigned idx, exp_lat, lat, c, rd_cnt, wr_cnt, en_c;
    logic [31:0] seen_addr, seen_data;
    logic        rdy_bad, stable_bad;
    eff = base + 32'($signed(imm));
    err = (eff % 4 != 0) || (eff >= 32'd128);
    idx = eff / 4;
    if (!err) idx = idx % 32;
    exp_data = (err || st) ? 32'h0 : ref_mem[idx];
    exp_lat  = err ? 1 : (st ? 2 : 3);
    if (!err && st) ref_mem[idx] = wdata;

    @(negedge clk);
    rif.req_valid = 1'b1; rif.req_is_store = st; rif.req_base = base;
    rif.req_imm = imm; rif.req_wdata = wdata; rif.req_rd = rd;
    check_eq("req_ready_idle", 32'(rif.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rif.req_valid = 1'b0;
    scramble_req();
    lat = 0; rd_cnt = 0; wr_cnt = 0; en_c = 0; rdy_bad = 1'b0;
    seen_addr = '0; seen_data = '0;
    for (c = 1; c <= 8; c++) begin
      if (rif.req_ready) rdy_bad = 1'b1;
      if (mif.mem_rd_en) begin rd_cnt++; en_c = c; seen_addr = 32'(mif.mem_rd_addr); end
      if (mif.mem_wr_en) begin
        wr_cnt++; en_c = c; seen_addr = 32'(mif.mem_wr_addr); seen_data = mif.mem_wr_data;
      end
      if (rif.resp_valid) begin lat = c; break; end
      @(negedge clk);
    end
    if (lat == 0) check_eq("resp_timeout", 32'd0, 32'd1);
    check_eq("latency", lat, exp_lat);
    check_eq("rd_en_count", rd_cnt, (!err && !st) ? 1 : 0);
    check_eq("wr_en_count", wr_cnt, (!err && st) ? 1 : 0);
    if (!err) begin
      check_eq("en_cycle", en_c, 1);
      check_eq("mem_addr", seen_addr, idx);
      if (st) check_eq("mem_wr_data", seen_data, wdata);
    end
    check_eq("resp_data", rif.resp_data, exp_data);
    check_eq("resp_rd", 32'(rif.resp_rd), 32'(rd));
    check_eq("resp_err", 32'(rif.resp_err), 32'(err));
    check_eq("req_ready_busy", 32'(rdy_bad), 32'd0);

    if (hold > 0) begin
      stable_bad = 1'b0;
      for (int unsigned h = 0; h < hold; h++) begin
        @(negedge clk);
        scramble_req();
        rif.req_valid = 1'($urandom);
        if (!rif.resp_valid || rif.resp_data !== exp_data || rif.resp_rd !== rd ||
            rif.resp_err !== err || rif.req_ready || mif.mem_rd_en || mif.mem_wr_en)
          stable_bad = 1'b1;
      end
      rif.req_valid = 1'b0;
      check_eq("backpressure_stable", 32'(stable_bad), 32'd0);
    end

    rif.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rif.resp_ready = 1'b0;
    check_eq("resp_valid_after_hs", 32'(rif.resp_valid), 32'd0);
    check_eq("req_ready_after_hs", 32'(rif.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] eff, base;
    logic [11:0] imm;
    int unsigned kind;
    int unsigned seen;

    // Reset with a request pending
    rif.resp_ready = 1'b0;
    scramble_req();
    rif.req_valid = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", 32'(rif.req_ready), 32'd0);
    check_eq("rst_enables", 32'({mif.mem_rd_en, mif.mem_wr_en}), 32'd0);
    check_eq("rst_resp_valid", 32'(rif.resp_valid), 32'd0);
    check_eq("rst_resp_data", rif.resp_data, 32'd0);
    rst = 1'b1;
    rif.req_valid = 1'b0;
    @(negedge clk);
    check_eq("post_rst_req_ready", 32'(rif.req_ready), 32'd1);

    // Store then load the same word
    run_req(1'b1, 32'h10, 12'h004, 32'hDEADBEEF, 5'd2, 0);
    run_req(1'b0, 32'h10, 12'h004, 32'h0, 5'd7, 0);
    // Negative immediate and 32-bit wrap
    run_req(1'b0, 32'h20, 12'hFFC, 32'h0, 5'd1, 0);
    run_req(1'b0, 32'hFFFFFFFC, 12'h008, 32'h0, 5'd4, 0);
    // Misaligned and out of range
    run_req(1'b0, 32'h11, 12'h000, 32'h0, 5'd9, 0);
    run_req(1'b0, 32'h80, 12'h000, 32'h0, 5'd10, 0);
    run_req(1'b1, 32'h7E, 12'h000, 32'h12345678, 5'd11, 2);
    // Backpressure on a load
    run_req(1'b0, 32'h14, 12'h000, 32'h0, 5'd12, 5);

    // Reset during WAIT of a load
    @(negedge clk);
    rif.req_valid = 1'b1; rif.req_is_store = 1'b0; rif.req_base = 32'h40;
    rif.req_imm = 12'h000; rif.req_rd = 5'd3;
    @(posedge clk);
    @(negedge clk);
    rif.req_valid = 1'b0;
    check_eq("mid_rst_issue_rd_en", 32'(mif.mem_rd_en), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_enables", 32'({mif.mem_rd_en, mif.mem_wr_en}), 32'd0);
    check_eq("mid_rst_resp_valid", 32'(rif.resp_valid), 32'd0);
    check_eq("mid_rst_req_ready", 32'(rif.req_ready), 32'd0);
    check_eq("mid_rst_rd_addr", 32'(mif.mem_rd_addr), 32'd0);
    check_eq("mid_rst_resp_rd", 32'(rif.resp_rd), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rif.resp_valid) seen++;
    end
    check_eq("mid_rst_no_resp", seen, 0);
    run_req(1'b0, 32'h10, 12'h004, 32'h0, 5'd13, 1);

    // Randomized mix of good, misaligned and out-of-range requests
    for (int unsigned i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 7)       eff = 32'($urandom_range(0, 31)) * 4;
      else if (kind == 7) eff = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
      else                eff = $urandom | 32'h80;
      imm  = 12'($urandom);
      base = eff - 32'($signed(imm));
      run_req(1'($urandom), base, imm, $urandom, 5'($urandom), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
